// File: rtl/bilat_pkg.sv
// Shared types and constants for the bilateral filter frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bilat_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Window size of the filter and the distance from its edge to its centre.
    localparam int BILAT_WIN  = 9;
    localparam int BILAT_HALF = 4;

    // Pixels needed after the last real pixel before the last window centre is emitted.
    function automatic int flush_len(input int width);
        return BILAT_HALF * width + BILAT_HALF;
    endfunction

endpackage

// File: rtl/bilat_frame_counter.sv
// Loadable up-counter with a terminal-count flag (count == last).
// Latency: count updates one cycle after inc/load; tc is combinational from the count.
// Backpressure: none; load has priority over inc.
module bilat_frame_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise step by one when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == last);

endmodule

// File: rtl/bilateral_frame_ctrl.sv
// Frame sequencer for the 9x9 bilateral filter: clears it, paces pixels, flushes, forwards results. Optional stall watchdog: BILAT_FRAME_TIMEOUT_EN.
// Latency: accepted pixel reaches flt_pixel one cycle later; filter result reaches out_pixel one cycle later.
// Backpressure: in_ready is high only while streaming; results are forwarded without backpressure.
module bilateral_frame_ctrl
    import bilat_pkg::*;
#(
    parameter int         IMAGE_WIDTH  = 320,
    parameter int         IMAGE_HEIGHT = 240,
    parameter logic [7:0] FLUSH_PIX    = 8'd0,
    parameter int         DRAIN_CYCLES = 3     // must be at least 1
`ifdef BILAT_FRAME_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_pixel,
    output logic        flt_rst,
    output logic        flt_valid,
    output logic [7:0]  flt_pixel,
    input  logic        flt_out_valid,
    input  logic [7:0]  flt_out_pixel,
    output logic        out_valid,
    output logic [7:0]  out_pixel,
    output logic        busy,
    output logic        frame_done,
    output logic [31:0] out_count,
    output logic        error
);

    localparam int NPIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int FLUSH_LEN = flush_len(IMAGE_WIDTH);
    localparam int PIX_W     = $clog2(NPIX + 1);
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam int DR_W      = $clog2(DRAIN_CYCLES + 1);

    state_t      state_q, state_d;
    logic        flt_rst_q, flt_rst_d;
    logic        flt_valid_q, flt_valid_d;
    logic [7:0]  flt_pixel_q, flt_pixel_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_pixel_q, out_pixel_d;
    logic [31:0] out_count_q, out_count_d;
    logic        error_d;

    logic handshake;
    logic forwarding;
    logic pix_tc;
    logic flush_tc;
    logic drain_tc;
    logic timeout_hit;

    assign handshake  = in_valid && (state_q == ST_STREAM);
    assign forwarding = (state_q == ST_STREAM) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);

    // Pixels accepted this frame; terminal count marks the last real pixel.
    bilat_frame_counter #(.WIDTH(PIX_W)) u_pix_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q != ST_STREAM),
        .load_val ('0),
        .inc      (handshake),
        .last     (PIX_W'(NPIX - 1)),
        .tc       (pix_tc)
    );

    // Flush pixel cycles; restarts from zero whenever we are not flushing.
    bilat_frame_counter #(.WIDTH(FL_W)) u_flush_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q != ST_FLUSH),
        .load_val ('0),
        .inc      (1'b1),
        .last     (FL_W'(FLUSH_LEN - 1)),
        .tc       (flush_tc)
    );

    // Settle cycles after the flush so the filter pipeline empties.
    bilat_frame_counter #(.WIDTH(DR_W)) u_drain_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q != ST_DRAIN),
        .load_val ('0),
        .inc      (1'b1),
        .last     (DR_W'(DRAIN_CYCLES - 1)),
        .tc       (drain_tc)
    );

`ifdef BILAT_FRAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic stall_tc;
    logic error_q;

    // Consecutive streaming cycles without a handshake.
    bilat_frame_counter #(.WIDTH(TO_W)) u_stall_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state_q != ST_STREAM) || handshake),
        .load_val ('0),
        .inc      (1'b1),
        .last     (TO_W'(TIMEOUT_CYCLES - 1)),
        .tc       (stall_tc)
    );

    assign timeout_hit = stall_tc && !handshake;

    // Sticky timeout flag, cleared by reset or the next frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // Frame sequencing and pixel pacing into the filter.
    always_comb begin
        state_d     = state_q;
        flt_valid_d = 1'b0;
        flt_pixel_d = 8'd0;
        error_d     = error;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR;
                    error_d = 1'b0;
                end
            end
            ST_CLR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (handshake) begin
                    flt_valid_d = 1'b1;
                    flt_pixel_d = in_pixel;
                    if (pix_tc) begin
                        state_d = ST_FLUSH;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_FLUSH;
                    error_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                flt_valid_d = 1'b1;
                flt_pixel_d = FLUSH_PIX;
                if (flush_tc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        flt_rst_d = (state_d == ST_CLR);
    end

    // Result forwarding and per-frame result count.
    always_comb begin
        out_valid_d = 1'b0;
        out_pixel_d = 8'd0;
        out_count_d = out_count_q;
        if ((state_q == ST_IDLE) && start) begin
            out_count_d = 32'd0;
        end else if (forwarding) begin
            out_valid_d = flt_out_valid;
            out_pixel_d = flt_out_pixel;
            if (flt_out_valid) begin
                out_count_d = out_count_q + 32'd1;
            end
        end
    end

    // State and output registers; reset holds the filter in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flt_rst_q   <= 1'b1;
            flt_valid_q <= 1'b0;
            flt_pixel_q <= 8'd0;
            out_valid_q <= 1'b0;
            out_pixel_q <= 8'd0;
            out_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            flt_rst_q   <= flt_rst_d;
            flt_valid_q <= flt_valid_d;
            flt_pixel_q <= flt_pixel_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready   = (state_q == ST_STREAM);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign flt_rst    = flt_rst_q;
    assign flt_valid  = flt_valid_q;
    assign flt_pixel  = flt_pixel_q;
    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign out_count  = out_count_q;

endmodule

// File: tb/tb_bilateral_frame_ctrl.sv
// Randomized bench for bilateral_frame_ctrl against a frame-timeline reference model.
// Latency: checks every cycle at the falling edge.
// Backpressure: drives in_valid gaps, stray starts and a mid-frame reset.
module tb_bilateral_frame_ctrl;

    localparam int         W    = 16;
    localparam int         H    = 8;
    localparam int         NPIX = W * H;
    localparam int         FLEN = 4 * W + 4;
    localparam int         DRN  = 3;
    localparam logic [7:0] FPIX = 8'h5A;
`ifdef BILAT_FRAME_TIMEOUT_EN
    localparam int TO    = 20;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 0;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        flt_rst;
    logic        flt_valid;
    logic [7:0]  flt_pixel;
    logic        flt_out_valid;
    logic [7:0]  flt_out_pixel;
    logic        out_valid;
    logic [7:0]  out_pixel;
    logic        busy;
    logic        frame_done;
    logic [31:0] out_count;
    logic        error;

    always #5 clk = ~clk;

    bilateral_frame_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .FLUSH_PIX    (FPIX),
        .DRAIN_CYCLES (DRN)
`ifdef BILAT_FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .flt_rst       (flt_rst),
        .flt_valid     (flt_valid),
        .flt_pixel     (flt_pixel),
        .flt_out_valid (flt_out_valid),
        .flt_out_pixel (flt_out_pixel),
        .out_valid     (out_valid),
        .out_pixel     (out_pixel),
        .busy          (busy),
        .frame_done    (frame_done),
        .out_count     (out_count),
        .error         (error)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is a timeline measured from the start edge.
    // m_t is the index of the visible cycle (0 = clear cycle); m_end is the
    // visible cycle of the last accepted pixel (or timeout), -1 until known.
    bit          m_active;
    bit          m_rstflag;
    int          m_t;
    int          m_end;
    int          m_hs;
    int          m_stall;
    logic        m_fv;
    logic [7:0]  m_fp;
    logic        m_ov;
    logic [7:0]  m_op;
    logic [31:0] m_cnt;
    logic        m_err;

    // Counts of DUT events seen in the current frame.
    int o_fv;
    int o_done;
    int o_ov;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_rstflag = 1'b1;
        m_t       = 0;
        m_end     = -1;
        m_hs      = 0;
        m_stall   = 0;
        m_fv      = 1'b0;
        m_fp      = 8'd0;
        m_ov      = 1'b0;
        m_op      = 8'd0;
        m_cnt     = 32'd0;
        m_err     = 1'b0;
    endtask

    // One clock: check what is visible now, drive inputs, advance the model.
    task automatic cycle(input logic drv_start, input logic drv_rst_n, input logic drv_in_valid);
        bit v_clr, v_stream, v_flush, v_drain, v_done, v_fwd, hs;
        @(negedge clk);
        v_clr    = m_active && (m_t == 0);
        v_stream = m_active && (m_t >= 1) && (m_end < 0);
        v_flush  = m_active && (m_end >= 0) && (m_t > m_end) && (m_t <= m_end + FLEN);
        v_drain  = m_active && (m_end >= 0) && (m_t > m_end + FLEN) && (m_t <= m_end + FLEN + DRN);
        v_done   = m_active && (m_end >= 0) && (m_t == m_end + FLEN + DRN + 1);
        v_fwd    = v_stream || v_flush || v_drain;

        chk_val("in_ready", in_ready, v_stream);
        chk_val("busy", busy, m_active);
        chk_val("flt_rst", flt_rst, v_clr || m_rstflag);
        chk_val("frame_done", frame_done, v_done);
        chk_val("flt_valid", flt_valid, m_fv);
        if (m_fv) chk_val("flt_pixel", flt_pixel, m_fp);
        chk_val("out_valid", out_valid, m_ov);
        if (m_ov) chk_val("out_pixel", out_pixel, m_op);
        chk_val("out_count", out_count, m_cnt);
        chk_val("error", error, m_err);
        if (flt_valid === 1'b1) o_fv++;
        if (frame_done === 1'b1) o_done++;
        if (out_valid === 1'b1) o_ov++;

        rst_n         = drv_rst_n;
        start         = drv_start;
        in_valid      = drv_in_valid;
        in_pixel      = 8'($urandom);
        flt_out_valid = 1'($urandom_range(0, 1));
        flt_out_pixel = 8'($urandom);

        if (!drv_rst_n) begin
            model_reset();
        end else begin
            m_rstflag = 1'b0;
            hs   = v_stream && drv_in_valid;
            m_fv = hs || v_flush;
            m_fp = hs ? in_pixel : FPIX;
            m_ov = v_fwd && flt_out_valid;
            m_op = flt_out_pixel;
            if (v_fwd && flt_out_valid) m_cnt = m_cnt + 32'd1;
            if (hs) begin
                m_hs++;
                m_stall = 0;
                if (m_hs == NPIX) m_end = m_t;
            end else if (v_stream) begin
                m_stall++;
                if (TO_EN && (m_stall == TO)) begin
                    m_end = m_t;
                    m_err = 1'b1;
                end
            end
            if (!m_active && drv_start) begin
                m_active = 1'b1;
                m_t      = 0;
                m_end    = -1;
                m_hs     = 0;
                m_stall  = 0;
                m_cnt    = 32'd0;
                m_err    = 1'b0;
            end else if (v_done) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
            end
        end
    endtask

    // mode 0: continuous, 1: 1-0-0 repeating, 2: random 50%.
    // rst_at >= 0 pulses reset once that many pixels are in; stop_at >= 0 stops input.
    task automatic run_frame(input int mode, input int rst_at, input int stop_at);
        int   n;
        logic s, r, iv;
        n      = 0;
        o_fv   = 0;
        o_done = 0;
        o_ov   = 0;
        cycle(1'b1, 1'b1, 1'b1);
        n++;
        while (m_active && (n < 3000)) begin
            s = ($urandom_range(0, 9) == 0);
            r = !((rst_at >= 0) && (m_hs >= rst_at));
            case (mode)
                0:       iv = 1'b1;
                1:       iv = ((n % 3) == 0);
                default: iv = 1'($urandom_range(0, 1));
            endcase
            if ((stop_at >= 0) && (m_hs >= stop_at)) iv = 1'b0;
            cycle(s, r, iv);
            n++;
        end
        chk_val("frame_within_budget", (n < 3000), 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        if (rst_at < 0) begin
            chk_val("frame_done_pulses", o_done, 1);
            chk_val("flt_valid_total", o_fv, ((stop_at >= 0) ? stop_at : NPIX) + FLEN);
            chk_val("out_count_vs_pulses", out_count, o_ov);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b1;
        in_valid      = 1'b1;
        in_pixel      = 8'd0;
        flt_out_valid = 1'b0;
        flt_out_pixel = 8'd0;
        model_reset();
        o_fv   = 0;
        o_done = 0;
        o_ov   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("rst_flt_rst", flt_rst, 1'b1);
        chk_val("rst_in_ready", in_ready, 1'b0);
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_out_count", out_count, 32'd0);

        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);

        run_frame(0, -1, -1);
        run_frame(1, -1, -1);
        run_frame(2, 50, -1);
        run_frame(2, -1, -1);
`ifdef BILAT_FRAME_TIMEOUT_EN
        run_frame(0, -1, 40);
        run_frame(0, -1, -1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
